// File: rtl/axi_info_pkg.sv
// Shared response codes and address classification for the
// AXI-Lite information block.
package axi_info_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDX_CONST,
        IDX_SCR,
        IDX_CNT_LO,
        IDX_CNT_HI,
        IDX_UNMAP
    } idx_kind_e;

    function automatic idx_kind_e classify(
        input int unsigned idx,
        input int unsigned n,
        input int unsigned s
    );
        if (idx < n)
            return IDX_CONST;
        else if (idx < n + s)
            return IDX_SCR;
        else if (idx == n + s)
            return IDX_CNT_LO;
        else if (idx == n + s + 1)
            return IDX_CNT_HI;
        else
            return IDX_UNMAP;
    endfunction

endpackage

// File: rtl/axi_info_ext.sv
// AXI-Lite slave: read-only constant words, byte-writable scratch
// words and a 64-bit free-running cycle counter.
module axi_info_ext
    import axi_info_pkg::*;
#(
    parameter int unsigned            N          = 6,
    parameter int unsigned            S          = 2,
    parameter logic [N-1:0][31:0]     DATA       = '0,
    parameter int unsigned            ADDR_WIDTH = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  s_axi_AWVALID,
    output logic                  s_axi_AWREADY,
    input  logic [ADDR_WIDTH-1:0] s_axi_AWADDR,
    input  logic                  s_axi_WVALID,
    output logic                  s_axi_WREADY,
    input  logic [31:0]           s_axi_WDATA,
    input  logic [3:0]            s_axi_WSTRB,
    output logic                  s_axi_BVALID,
    input  logic                  s_axi_BREADY,
    output logic [1:0]            s_axi_BRESP,
    input  logic                  s_axi_ARVALID,
    output logic                  s_axi_ARREADY,
    input  logic [ADDR_WIDTH-1:0] s_axi_ARADDR,
    output logic                  s_axi_RVALID,
    input  logic                  s_axi_RREADY,
    output logic [31:0]           s_axi_RDATA,
    output logic [1:0]            s_axi_RRESP
);

    localparam int unsigned SW = (S == 0) ? 1 : S;

    generate
        if (4 * (N + S + 2) > (1 << ADDR_WIDTH)) begin : g_addr_chk
            $error("axi_info_ext: ADDR_WIDTH too small for N+S+2 words");
        end
    endgenerate

    logic                  r_en;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [31:0]           r_w_data;
    logic [3:0]            r_w_strb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;
    logic [63:0]           r_cnt;
    logic [31:0]           r_snap;
    logic [31:0]           r_scr [SW];

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [31:0]           w_wr_data;
    logic [3:0]            w_wr_strb;
    int unsigned           w_wr_idx;
    int unsigned           w_ar_idx;
    idx_kind_e             w_wr_kind;
    idx_kind_e             w_ar_kind;
    logic [31:0]           w_rd_data;
    logic [1:0]            w_rd_resp;
    logic [1:0]            w_wr_resp;

    // r_en keeps every ready low until the first edge after reset
    assign s_axi_AWREADY = r_en & ~r_aw_held & ~r_bvalid;
    assign s_axi_WREADY  = r_en & ~r_w_held & ~r_bvalid;
    assign s_axi_ARREADY = r_en & ~r_rvalid;
    assign s_axi_BVALID  = r_bvalid;
    assign s_axi_BRESP   = r_bresp;
    assign s_axi_RVALID  = r_rvalid;
    assign s_axi_RDATA   = r_rdata;
    assign s_axi_RRESP   = r_rresp;

    assign w_aw_hs   = s_axi_AWVALID & s_axi_AWREADY;
    assign w_w_hs    = s_axi_WVALID & s_axi_WREADY;
    assign w_ar_hs   = s_axi_ARVALID & s_axi_ARREADY;
    assign w_commit  = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_wr_addr = r_aw_held ? r_aw_addr : s_axi_AWADDR;
    assign w_wr_data = r_w_held ? r_w_data : s_axi_WDATA;
    assign w_wr_strb = r_w_held ? r_w_strb : s_axi_WSTRB;
    assign w_wr_idx  = 32'(w_wr_addr >> 2);
    assign w_ar_idx  = 32'(s_axi_ARADDR >> 2);
    assign w_wr_kind = classify(w_wr_idx, N, S);
    assign w_ar_kind = classify(w_ar_idx, N, S);

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        unique case (w_ar_kind)
            IDX_CONST: begin
                for (int unsigned i = 0; i < N; i++)
                    if (w_ar_idx == i) w_rd_data = DATA[i];
            end
            IDX_SCR: begin
                for (int unsigned i = 0; i < S; i++)
                    if (w_ar_idx == N + i) w_rd_data = r_scr[i];
            end
            IDX_CNT_LO: w_rd_data = r_cnt[31:0];
            IDX_CNT_HI: w_rd_data = r_snap;
            default:    w_rd_resp = RESP_DECERR;
        endcase
    end

    always_comb begin
        w_wr_resp = RESP_SLVERR;
        unique case (w_wr_kind)
            IDX_SCR:   w_wr_resp = RESP_OKAY;
            IDX_UNMAP: w_wr_resp = RESP_DECERR;
            default:   w_wr_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_en      <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_addr <= '0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= '0;
            r_cnt     <= '0;
            r_snap    <= '0;
            for (int unsigned i = 0; i < SW; i++)
                r_scr[i] <= '0;
        end else begin
            r_en  <= 1'b1;
            r_cnt <= r_cnt + 64'd1;

            if (r_bvalid && s_axi_BREADY)
                r_bvalid <= 1'b0;

            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_resp;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_addr <= s_axi_AWADDR;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= s_axi_WDATA;
                    r_w_strb <= s_axi_WSTRB;
                end
            end

            if (w_commit && w_wr_kind == IDX_SCR) begin
                for (int unsigned i = 0; i < S; i++)
                    if (w_wr_idx == N + i)
                        for (int b = 0; b < 4; b++)
                            if (w_wr_strb[b])
                                r_scr[i][b*8 +: 8] <= w_wr_data[b*8 +: 8];
            end

            // Read mux sees pre-commit scratch, so a coincident read
            // returns the old value.
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
                if (w_ar_kind == IDX_CNT_LO)
                    r_snap <= r_cnt[63:32];
            end else if (r_rvalid && s_axi_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_info_ext.sv
// Directed self-checking bench for axi_info_ext (N=6, S=2, 8-bit
// addresses: scratch at 0x18/0x1C, counter at 0x20/0x24).
module tb_axi_info_ext;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        s_axi_AWVALID;
    logic        s_axi_AWREADY;
    logic [7:0]  s_axi_AWADDR;
    logic        s_axi_WVALID;
    logic        s_axi_WREADY;
    logic [31:0] s_axi_WDATA;
    logic [3:0]  s_axi_WSTRB;
    logic        s_axi_BVALID;
    logic        s_axi_BREADY;
    logic [1:0]  s_axi_BRESP;
    logic        s_axi_ARVALID;
    logic        s_axi_ARREADY;
    logic [7:0]  s_axi_ARADDR;
    logic        s_axi_RVALID;
    logic        s_axi_RREADY;
    logic [31:0] s_axi_RDATA;
    logic [1:0]  s_axi_RRESP;

    int checks = 0;
    int errors = 0;

    axi_info_ext #(
        .N          (6),
        .S          (2),
        .DATA       ({128'h0, 32'h1234_5678, 32'h4649_4E4E}),
        .ADDR_WIDTH (8)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .s_axi_AWVALID (s_axi_AWVALID),
        .s_axi_AWREADY (s_axi_AWREADY),
        .s_axi_AWADDR  (s_axi_AWADDR),
        .s_axi_WVALID  (s_axi_WVALID),
        .s_axi_WREADY  (s_axi_WREADY),
        .s_axi_WDATA   (s_axi_WDATA),
        .s_axi_WSTRB   (s_axi_WSTRB),
        .s_axi_BVALID  (s_axi_BVALID),
        .s_axi_BREADY  (s_axi_BREADY),
        .s_axi_BRESP   (s_axi_BRESP),
        .s_axi_ARVALID (s_axi_ARVALID),
        .s_axi_ARREADY (s_axi_ARREADY),
        .s_axi_ARADDR  (s_axi_ARADDR),
        .s_axi_RVALID  (s_axi_RVALID),
        .s_axi_RREADY  (s_axi_RREADY),
        .s_axi_RDATA   (s_axi_RDATA),
        .s_axi_RRESP   (s_axi_RRESP)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic do_read(input logic [7:0] a, output logic [31:0] d,
                           output logic [1:0] r, output logic lat_ok);
        int n;
        @(negedge ap_clk);
        s_axi_ARADDR  = a;
        s_axi_ARVALID = 1'b1;
        n = 0;
        while (!s_axi_ARREADY && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        if (!s_axi_ARREADY) begin
            checks++; errors++;
            $display("FAIL ar_timeout addr=%h", a);
            s_axi_ARVALID = 1'b0;
            d = '0; r = '0; lat_ok = 1'b0;
            return;
        end
        @(posedge ap_clk); #1;
        s_axi_ARVALID = 1'b0;
        lat_ok = s_axi_RVALID;
        d = s_axi_RDATA;
        r = s_axi_RRESP;
        s_axi_RREADY = 1'b1;
        @(posedge ap_clk); #1;
        s_axi_RREADY = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] strb, input int lead,
                            output logic [1:0] resp, output logic lat_ok);
        logic aw_done, w_done, aw_hs, w_hs;
        int k;
        aw_done = 1'b0; w_done = 1'b0; k = 0;
        @(negedge ap_clk);
        s_axi_WDATA  = d;
        s_axi_WSTRB  = strb;
        s_axi_WVALID = 1'b1;
        while (!(aw_done && w_done) && k < 60) begin
            if (k == lead) begin
                s_axi_AWADDR  = a;
                s_axi_AWVALID = 1'b1;
            end
            aw_hs = s_axi_AWVALID & s_axi_AWREADY;
            w_hs  = s_axi_WVALID & s_axi_WREADY;
            @(posedge ap_clk); #1;
            if (aw_hs) begin s_axi_AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin s_axi_WVALID  = 1'b0; w_done  = 1'b1; end
            if (!(aw_done && w_done)) @(negedge ap_clk);
            k++;
        end
        if (!(aw_done && w_done)) begin
            checks++; errors++;
            $display("FAIL wr_timeout addr=%h", a);
            s_axi_AWVALID = 1'b0; s_axi_WVALID = 1'b0;
            resp = '0; lat_ok = 1'b0;
            return;
        end
        lat_ok = s_axi_BVALID;
        resp = s_axi_BRESP;
        s_axi_BREADY = 1'b1;
        @(posedge ap_clk); #1;
        s_axi_BREADY = 1'b0;
    endtask

    task automatic test_reset;
        ap_rst_n = 1'b1;
        #2 ap_rst_n = 1'b0;
        #1;
        checks++;
        if ({s_axi_AWREADY, s_axi_WREADY, s_axi_ARREADY, s_axi_BVALID,
             s_axi_RVALID} !== 5'b0 || s_axi_BRESP !== 2'b0 ||
            s_axi_RRESP !== 2'b0 || s_axi_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b%b%b bv=%b rv=%b want 0",
                     s_axi_AWREADY, s_axi_WREADY, s_axi_ARREADY,
                     s_axi_BVALID, s_axi_RVALID);
        end
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        checks++;
        if (s_axi_AWREADY !== 1'b0 || s_axi_ARREADY !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got aw=%b ar=%b want 0",
                     s_axi_AWREADY, s_axi_ARREADY);
        end
        @(negedge ap_clk);
        checks++;
        if ({s_axi_AWREADY, s_axi_WREADY, s_axi_ARREADY} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_release got %b%b%b want 111",
                     s_axi_AWREADY, s_axi_WREADY, s_axi_ARREADY);
        end
    endtask

    task automatic test_const_read;
        logic [31:0] d; logic [1:0] r; logic lat;
        do_read(8'h00, d, r, lat);
        checks++;
        if (d !== 32'h4649_4E4E || r !== 2'b00 || lat !== 1'b1) begin
            errors++;
            $display("FAIL const0 got d=%h r=%b lat=%b want 46494e4e 00 1",
                     d, r, lat);
        end
        do_read(8'h05, d, r, lat);
        checks++;
        if (d !== 32'h1234_5678 || r !== 2'b00) begin
            errors++;
            $display("FAIL const1_lowbits got d=%h r=%b want 12345678 00", d, r);
        end
        do_read(8'h14, d, r, lat);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++;
            $display("FAIL const5 got d=%h r=%b want 0 00", d, r);
        end
    endtask

    task automatic test_scratch;
        logic [31:0] d; logic [1:0] r; logic lat;
        do_write(8'h18, 32'hDEAD_BEEF, 4'b0101, 3, r, lat);
        checks++;
        if (r !== 2'b00 || lat !== 1'b1) begin
            errors++;
            $display("FAIL scr0_wr got resp=%b lat=%b want 00 1", r, lat);
        end
        do_read(8'h18, d, r, lat);
        checks++;
        if (d !== 32'h00AD_00EF || r !== 2'b00) begin
            errors++;
            $display("FAIL scr0_strb got d=%h want 00ad00ef", d);
        end
        do_write(8'h1C, 32'h1122_3344, 4'b1111, 0, r, lat);
        do_write(8'h1E, 32'hAABB_CCDD, 4'b1000, 1, r, lat);
        do_read(8'h1C, d, r, lat);
        checks++;
        if (d !== 32'hAA22_3344 || r !== 2'b00) begin
            errors++;
            $display("FAIL scr1_merge got d=%h want aa223344", d);
        end
    endtask

    task automatic test_errors;
        logic [31:0] d; logic [1:0] r; logic lat;
        do_write(8'h00, 32'hFFFF_FFFF, 4'b1111, 0, r, lat);
        checks++;
        if (r !== 2'b10) begin
            errors++;
            $display("FAIL wr_const got resp=%b want 10", r);
        end
        do_read(8'h00, d, r, lat);
        checks++;
        if (d !== 32'h4649_4E4E) begin
            errors++;
            $display("FAIL const_unchanged got d=%h want 46494e4e", d);
        end
        do_write(8'h20, 32'h0, 4'b1111, 2, r, lat);
        checks++;
        if (r !== 2'b10) begin
            errors++;
            $display("FAIL wr_counter got resp=%b want 10", r);
        end
        do_write(8'hFC, 32'h1234_0000, 4'b1111, 0, r, lat);
        checks++;
        if (r !== 2'b11) begin
            errors++;
            $display("FAIL wr_unmapped got resp=%b want 11", r);
        end
        do_read(8'hFC, d, r, lat);
        checks++;
        if (d !== 32'h0 || r !== 2'b11) begin
            errors++;
            $display("FAIL rd_unmapped got d=%h r=%b want 0 11", d, r);
        end
        do_read(8'h28, d, r, lat);
        checks++;
        if (r !== 2'b11) begin
            errors++;
            $display("FAIL rd_first_unmapped got r=%b want 11", r);
        end
    endtask

    task automatic test_counter;
        logic [31:0] d; logic [1:0] r; logic lat;
        @(negedge ap_clk);
        force dut.r_cnt = 64'h0000_0001_FFFF_FFFF;
        s_axi_ARADDR  = 8'h20;
        s_axi_ARVALID = 1'b1;
        @(posedge ap_clk); #1;
        release dut.r_cnt;
        s_axi_ARVALID = 1'b0;
        checks++;
        if (s_axi_RVALID !== 1'b1 || s_axi_RDATA !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL cnt_low got v=%b d=%h want 1 ffffffff",
                     s_axi_RVALID, s_axi_RDATA);
        end
        s_axi_RREADY = 1'b1;
        @(posedge ap_clk); #1;
        s_axi_RREADY = 1'b0;
        repeat (5) @(negedge ap_clk);
        do_read(8'h24, d, r, lat);
        checks++;
        if (d !== 32'h1 || r !== 2'b00) begin
            errors++;
            $display("FAIL cnt_snapshot got d=%h r=%b want 1 00", d, r);
        end
    endtask

    task automatic test_stall;
        int bad;
        @(negedge ap_clk);
        s_axi_AWADDR = 8'h1C; s_axi_AWVALID = 1'b1;
        s_axi_WDATA = 32'hCAFE_F00D; s_axi_WSTRB = 4'hF; s_axi_WVALID = 1'b1;
        s_axi_ARADDR = 8'h04; s_axi_ARVALID = 1'b1;
        @(posedge ap_clk); #1;
        s_axi_AWVALID = 1'b0; s_axi_WVALID = 1'b0; s_axi_ARVALID = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            if (s_axi_BVALID !== 1'b1 || s_axi_BRESP !== 2'b00 ||
                s_axi_RVALID !== 1'b1 || s_axi_RDATA !== 32'h1234_5678 ||
                s_axi_RRESP !== 2'b00 || s_axi_AWREADY !== 1'b0 ||
                s_axi_WREADY !== 1'b0 || s_axi_ARREADY !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold got %0d bad cycles want 0 (bv=%b rv=%b d=%h)",
                     bad, s_axi_BVALID, s_axi_RVALID, s_axi_RDATA);
        end
        s_axi_BREADY = 1'b1; s_axi_RREADY = 1'b1;
        @(posedge ap_clk); #1;
        s_axi_BREADY = 1'b0; s_axi_RREADY = 1'b0;
        checks++;
        if (s_axi_BVALID !== 1'b0 || s_axi_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got bv=%b rv=%b want 0 0",
                     s_axi_BVALID, s_axi_RVALID);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d; logic [1:0] r; logic lat;
        int beats;
        @(negedge ap_clk);
        s_axi_AWADDR = 8'h18; s_axi_AWVALID = 1'b1;
        s_axi_WDATA = 32'h5555_5555; s_axi_WSTRB = 4'hF; s_axi_WVALID = 1'b1;
        s_axi_ARADDR = 8'h18; s_axi_ARVALID = 1'b1;
        @(posedge ap_clk); #1;
        s_axi_AWVALID = 1'b0; s_axi_WVALID = 1'b0; s_axi_ARVALID = 1'b0;
        checks++;
        if (s_axi_RDATA !== 32'h00AD_00EF || s_axi_BVALID !== 1'b1) begin
            errors++;
            $display("FAIL coincide_prewrite got d=%h bv=%b want 00ad00ef 1",
                     s_axi_RDATA, s_axi_BVALID);
        end
        s_axi_BREADY = 1'b1; s_axi_RREADY = 1'b1;
        @(posedge ap_clk); #1;
        s_axi_BREADY = 1'b0; s_axi_RREADY = 1'b0;
        do_read(8'h18, d, r, lat);
        checks++;
        if (d !== 32'h5555_5555) begin
            errors++;
            $display("FAIL coincide_postwrite got d=%h want 55555555", d);
        end
        @(negedge ap_clk);
        s_axi_ARADDR = 8'h00; s_axi_ARVALID = 1'b1; s_axi_RREADY = 1'b1;
        beats = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            if (s_axi_RVALID === 1'b1) beats++;
        end
        s_axi_ARVALID = 1'b0;
        @(negedge ap_clk);
        s_axi_RREADY = 1'b0;
        checks++;
        if (beats != 5) begin
            errors++;
            $display("FAIL b2b_rate got %0d beats want 5", beats);
        end
    endtask

    task automatic test_reset_midwrite;
        logic [31:0] d; logic [1:0] r; logic lat;
        int seen;
        @(negedge ap_clk);
        s_axi_AWADDR = 8'h18; s_axi_AWVALID = 1'b1;
        @(posedge ap_clk); #1;
        s_axi_AWVALID = 1'b0;
        checks++;
        if (s_axi_AWREADY !== 1'b0 || s_axi_WREADY !== 1'b1) begin
            errors++;
            $display("FAIL aw_held got aw=%b w=%b want 0 1",
                     s_axi_AWREADY, s_axi_WREADY);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (s_axi_WREADY !== 1'b0 || s_axi_BVALID !== 1'b0 ||
            s_axi_ARREADY !== 1'b0) begin
            errors++;
            $display("FAIL reset_immediate got w=%b bv=%b ar=%b want 0",
                     s_axi_WREADY, s_axi_BVALID, s_axi_ARREADY);
        end
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            if (s_axi_BVALID !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL no_stale_b got %0d bvalid cycles want 0", seen);
        end
        do_write(8'h1C, 32'hA5A5_A5A5, 4'hF, 0, r, lat);
        checks++;
        if (r !== 2'b00 || lat !== 1'b1) begin
            errors++;
            $display("FAIL fresh_write got resp=%b lat=%b want 00 1", r, lat);
        end
        do_read(8'h18, d, r, lat);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL scr_cleared got d=%h want 0", d);
        end
        do_read(8'h1C, d, r, lat);
        checks++;
        if (d !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL fresh_readback got d=%h want a5a5a5a5", d);
        end
    endtask

    initial begin
        s_axi_AWVALID = 1'b0; s_axi_AWADDR = '0;
        s_axi_WVALID = 1'b0; s_axi_WDATA = '0; s_axi_WSTRB = '0;
        s_axi_BREADY = 1'b0;
        s_axi_ARVALID = 1'b0; s_axi_ARADDR = '0;
        s_axi_RREADY = 1'b0;
        test_reset;
        test_const_read;
        test_scratch;
        test_errors;
        test_counter;
        test_stall;
        test_back_to_back;
        test_reset_midwrite;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_info_ext.md
AXI_INFO_EXT -- requirements
Module: axi_info_ext

Interface
REQ-001 SHALL have parameter N, default 6: number of read-only constant words, 1..64.
REQ-002 SHALL have parameter S, default 2: number of writable scratch words, 0..16.
REQ-003 SHALL have parameter DATA, default all-zero array of N 32-bit words: constant word contents, index 0 first.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8: AXI-Lite byte address width; elaboration SHALL fail if 4*(N+S+2) > 2**ADDR_WIDTH.
REQ-005 SHALL have ports ap_clk (in, 1, the only clock) and ap_rst_n (in, 1, reset). One clock; reset is asynchronous and active-low.
REQ-006 SHALL have write ports s_axi_AWVALID in 1, s_axi_AWREADY out 1, s_axi_AWADDR in ADDR_WIDTH, s_axi_WVALID in 1, s_axi_WREADY out 1, s_axi_WDATA in 32, s_axi_WSTRB in 4, s_axi_BVALID out 1, s_axi_BREADY in 1, s_axi_BRESP out 2.
REQ-007 SHALL have read ports s_axi_ARVALID in 1, s_axi_ARREADY out 1, s_axi_ARADDR in ADDR_WIDTH, s_axi_RVALID out 1, s_axi_RREADY in 1, s_axi_RDATA out 32, s_axi_RRESP out 2.

Function
REQ-008 SHALL decode word index = ADDR[ADDR_WIDTH-1:2], ignoring ADDR[1:0]: index 0..N-1 constants, N..N+S-1 scratch, N+S counter low, N+S+1 counter high, above that unmapped.
REQ-009 SHALL keep a 64-bit free-running counter, 0 after reset, +1 every cycle, wrapping 2**64-1 -> 0.
REQ-010 SHALL, on a read of counter low, return the current low half and capture the current high half into a 32-bit snapshot in the same cycle; a read of counter high SHALL return the snapshot.
REQ-011 SHALL accept AW and W independently: AWREADY=1 while no address is held and BVALID=0; WREADY=1 while no data is held and BVALID=0; each holds one beat.
REQ-012 SHALL commit the write in the cycle both address and data are held (including when both handshake in the same cycle), then assert BVALID the next cycle and clear both holds.
REQ-013 SHALL on scratch commit update byte lane i only where WSTRB[i]=1; BRESP=OKAY (2'b00).
REQ-014 SHALL on write to constants or counter leave state unchanged, BRESP=SLVERR (2'b10); unmapped: no change, BRESP=DECERR (2'b11).
REQ-015 SHALL hold BVALID and BRESP stable until BREADY=1; BVALID drops the cycle after handshake.
REQ-016 SHALL drive ARREADY=!RVALID; on AR handshake register RDATA/RRESP and assert RVALID the next cycle (latency 1); one read outstanding.
REQ-017 SHALL return RRESP=OKAY for mapped indices, DECERR with RDATA=0 for unmapped.
REQ-018 SHALL hold RVALID, RDATA, RRESP stable until RREADY=1; back-to-back reads reach one beat per 2 cycles.
REQ-019 SHALL, when an AR handshake and a scratch commit coincide on the same word, return the pre-write value.
REQ-020 SHALL treat read and write channels as fully independent; neither stalls the other.

Reset
REQ-021 SHALL on ap_rst_n=0 immediately force AWREADY=0, WREADY=0, BVALID=0, ARREADY=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, clear holds, scratch, counter and snapshot to 0.
REQ-022 SHALL drop any in-flight transaction on reset without a response; ready outputs rise first cycle after deassertion.

Structure
REQ-023 SHALL place response codes (OKAY, SLVERR, DECERR) and the index-classification enum in shared package axi_info_pkg.
REQ-024 SHALL be one flat module; no sub-module is needed (counter, decode and channels inline).

Verification
REQ-025 Defaults, DATA[0]=32'h4649_4E4E: read addr 0x00 -> RDATA 32'h4649_4E4E, RRESP 00, RVALID 1 cycle after ARREADY&ARVALID.
REQ-026 Write addr 0x18 WDATA 32'hDEAD_BEEF WSTRB 4'b0101, W presented 3 cycles before AW -> BRESP 00; read 0x18 -> 32'h00AD_00EF.
REQ-027 Write 0x00 -> BRESP 10, DATA[0] unchanged; read/write 0xFC -> RRESP/BRESP 11, RDATA 0.
REQ-028 Preload counter-low 0xFFFF_FFFF via force: read 0x20 then, 5 cycles later, 0x24 -> high equals value at the low read, not later.
REQ-029 BREADY/RREADY held 0 for 10 cycles -> BVALID/RVALID, data and resp stable; AWREADY, WREADY, ARREADY stay 0.
REQ-030 Assert ap_rst_n=0 mid-write (AW held, W pending) -> no B response; after release write 0x1C gets fresh OKAY, scratch reads 0.
